// File: rtl/cafeteira_pkg.sv
`default_nettype none
// ============================================================================
// Module : cafeteira_pkg
// Brief  : State encodings, drink/button mapping and helpers shared by the
//          drink controller and the purchase verifier.
// Rev    : 1.0 - initial release
// ============================================================================
package cafeteira_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'b000,
        PREPARO = 3'b001,
        ENTREGA = 3'b010,
        ERRO    = 3'b011
    } estado_t;

    localparam logic [3:0] c_BT_CAPUCCINO     = 4'b0001;
    localparam logic [3:0] c_BT_CAFE_LEITE    = 4'b0010;
    localparam logic [3:0] c_BT_CHA_CAMOMILA  = 4'b0100;
    localparam logic [3:0] c_BT_CAFE_EXPRESSO = 4'b1000;
    localparam logic [2:0] c_SEM_CEDULA       = 3'b000;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic int maximo(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controle_preparo_if.sv
`default_nettype none
// ============================================================================
// Module : controle_preparo_if
// Brief  : Button/note inputs and status outputs of the drink controller.
// Rev    : 1.0 - initial release
// ============================================================================
interface controle_preparo_if;
    logic [2:0] chaves_cedulas;
    logic [3:0] bt;
    logic       d_valor;
    logic [3:0] led_bebida;
    logic       led_erro;
    logic       ocupado;
    logic       entregue;
    logic [2:0] estado;

    modport master (
        output chaves_cedulas, bt, d_valor,
        input  led_bebida, led_erro, ocupado, entregue, estado
    );

    modport slave (
        input  chaves_cedulas, bt, d_valor,
        output led_bebida, led_erro, ocupado, entregue, estado
    );
endinterface
`default_nettype wire

// File: rtl/controle_preparo_temporizador.sv
`default_nettype none
// ============================================================================
// Module : temporizador
// Brief  : Saturating down-counter; fim flags the second-to-last cycle of the
//          loaded interval so the controller can register its outputs.
// Rev    : 1.0 - initial release
// ============================================================================
module temporizador #(
    parameter int LARGURA = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               carga,
    input  wire logic [LARGURA-1:0] valor,
    output logic                    fim
);

    logic [LARGURA-1:0] r_contagem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contagem <= '0;
        end else if (carga) begin
            r_contagem <= valor;
        end else if (r_contagem != '0) begin
            r_contagem <= r_contagem - 1'b1;
        end
    end

    // Count 1 means exactly one cycle remains after this one.
    assign fim = (r_contagem == LARGURA'(1));

endmodule
`default_nettype wire

// File: rtl/controle_preparo.sv
`default_nettype none
// ============================================================================
// Module : controle_preparo
// Brief  : Drink preparation controller: request decode, timed PREPARO /
//          ENTREGA / ERRO sequence and registered status outputs.
// Rev    : 1.0 - initial release
// ============================================================================
module controle_preparo
    import cafeteira_pkg::*;
#(
    parameter int TEMPO_PREPARO = 50_000_000,
    parameter int TEMPO_ENTREGA = 25_000_000,
    parameter int TEMPO_ERRO    = 25_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    controle_preparo_if.slave barramento
);

    localparam int c_MAIOR   = maximo(TEMPO_PREPARO, maximo(TEMPO_ENTREGA, TEMPO_ERRO));
    localparam int c_LARGURA = maximo(1, $clog2(c_MAIOR));

    // Counter is loaded with length-1 so the largest interval fits the width.
    localparam logic [c_LARGURA-1:0] c_CARGA_PREPARO = c_LARGURA'(TEMPO_PREPARO - 1);
    localparam logic [c_LARGURA-1:0] c_CARGA_ENTREGA = c_LARGURA'(TEMPO_ENTREGA - 1);
    localparam logic [c_LARGURA-1:0] c_CARGA_ERRO    = c_LARGURA'(TEMPO_ERRO - 1);

    estado_t              r_estado;
    logic [3:0]           r_bt;
    logic                 r_armado;
    logic [3:0]           r_led_bebida;
    logic                 r_led_erro;
    logic                 r_ocupado;
    logic                 r_entregue;
    logic                 r_ultimo;

    logic [3:0]           w_borda;
    logic                 w_pedido;
    logic                 w_aceito;
    logic                 w_carga;
    logic [c_LARGURA-1:0] w_valor;
    logic                 w_fim;

    // r_armado keeps the first cycle after reset as a pure bt sample.
    assign w_borda  = barramento.bt & ~r_bt;
    assign w_pedido = r_armado && (w_borda != 4'b0000);
    assign w_aceito = eh_one_hot(w_borda) && eh_one_hot(barramento.bt)
                   && (barramento.chaves_cedulas != c_SEM_CEDULA) && !barramento.d_valor;

    assign w_carga  = ((r_estado == OCIOSO) && w_pedido) || ((r_estado == PREPARO) && r_ultimo);
    assign w_valor  = (r_estado == PREPARO) ? c_CARGA_ENTREGA :
                      (w_aceito ? c_CARGA_PREPARO : c_CARGA_ERRO);

    temporizador #(
        .LARGURA (c_LARGURA)
    ) u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .carga (w_carga),
        .valor (w_valor),
        .fim   (w_fim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= OCIOSO;
            r_bt         <= 4'b0000;
            r_armado     <= 1'b0;
            r_led_bebida <= 4'b0000;
            r_led_erro   <= 1'b0;
            r_ocupado    <= 1'b0;
            r_entregue   <= 1'b0;
            r_ultimo     <= 1'b0;
        end else begin
            r_bt     <= barramento.bt;
            r_armado <= 1'b1;
            case (r_estado)
                OCIOSO: begin
                    if (w_pedido) begin
                        r_ocupado <= 1'b1;
                        if (w_aceito) begin
                            r_estado     <= PREPARO;
                            r_led_bebida <= barramento.bt;
                            r_ultimo     <= (TEMPO_PREPARO == 1);
                        end else begin
                            r_estado   <= ERRO;
                            r_led_erro <= 1'b1;
                            r_ultimo   <= (TEMPO_ERRO == 1);
                        end
                    end
                end
                PREPARO: begin
                    if (r_ultimo) begin
                        r_estado   <= ENTREGA;
                        r_ultimo   <= (TEMPO_ENTREGA == 1);
                        r_entregue <= (TEMPO_ENTREGA == 1);
                    end else begin
                        r_ultimo <= w_fim;
                    end
                end
                ENTREGA: begin
                    if (r_ultimo) begin
                        r_estado     <= OCIOSO;
                        r_led_bebida <= 4'b0000;
                        r_ocupado    <= 1'b0;
                        r_entregue   <= 1'b0;
                        r_ultimo     <= 1'b0;
                    end else begin
                        r_ultimo   <= w_fim;
                        r_entregue <= w_fim;
                    end
                end
                ERRO: begin
                    if (r_ultimo) begin
                        r_estado   <= OCIOSO;
                        r_led_erro <= 1'b0;
                        r_ocupado  <= 1'b0;
                        r_ultimo   <= 1'b0;
                    end else begin
                        r_ultimo <= w_fim;
                    end
                end
                default: begin
                    r_estado     <= OCIOSO;
                    r_led_bebida <= 4'b0000;
                    r_led_erro   <= 1'b0;
                    r_ocupado    <= 1'b0;
                    r_entregue   <= 1'b0;
                    r_ultimo     <= 1'b0;
                end
            endcase
        end
    end

    assign barramento.led_bebida = r_led_bebida;
    assign barramento.led_erro   = r_led_erro;
    assign barramento.ocupado    = r_ocupado;
    assign barramento.entregue   = r_entregue;
    assign barramento.estado     = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_controle_preparo.sv
`default_nettype none
// ============================================================================
// Module : tb_controle_preparo
// Brief  : Directed and randomized bench for controle_preparo against a
//          cycle-count behavioural model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_controle_preparo;
    import cafeteira_pkg::*;

    localparam int TP = 8;
    localparam int TE = 4;
    localparam int TR = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_erros  = 0;
    bit   comparar = 1'b0;

    controle_preparo_if barramento ();

    controle_preparo #(
        .TEMPO_PREPARO (TP),
        .TEMPO_ENTREGA (TE),
        .TEMPO_ERRO    (TR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .barramento (barramento)
    );

    always #5 clk = ~clk;

    task automatic conferir(input string nome, input logic [3:0] atual, input logic [3:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_erros++;
            $display("FAIL %s at %0t: got %b expected %b", nome, $time, atual, esperado);
        end
    endtask

    task automatic entrada(input logic [2:0] ch, input logic [3:0] b, input logic dv);
        barramento.chaves_cedulas = ch;
        barramento.bt             = b;
        barramento.d_valor        = dv;
    endtask

    task automatic tudo_zero(input string nome);
        conferir({nome, "_estado"},   {1'b0, barramento.estado}, 4'd0);
        conferir({nome, "_led"},      barramento.led_bebida,     4'd0);
        conferir({nome, "_erro"},     {3'b0, barramento.led_erro}, 4'd0);
        conferir({nome, "_ocupado"},  {3'b0, barramento.ocupado},  4'd0);
        conferir({nome, "_entregue"}, {3'b0, barramento.entregue}, 4'd0);
    endtask

    // Model: mode 0 idle, 1 preparing, 2 delivering, 3 error; m_rest counts cycles left.
    int         m_modo;
    int         m_rest;
    logic [3:0] m_bebida;
    logic [3:0] m_bt_ant;
    logic [3:0] m_borda;
    bit         m_armado;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_modo = 0; m_rest = 0; m_bebida = 4'd0; m_bt_ant = 4'd0; m_armado = 1'b0;
        end else begin
            m_borda  = barramento.bt & ~m_bt_ant;
            m_bt_ant = barramento.bt;
            if (m_modo == 0) begin
                if (m_armado && m_borda != 4'd0) begin
                    if ($countones(m_borda) == 1 && $countones(barramento.bt) == 1 &&
                        barramento.chaves_cedulas != 3'd0 && barramento.d_valor == 1'b0) begin
                        m_modo = 1; m_rest = TP; m_bebida = barramento.bt;
                    end else begin
                        m_modo = 3; m_rest = TR;
                    end
                end
            end else begin
                m_rest = m_rest - 1;
                if (m_rest == 0) begin
                    if (m_modo == 1) begin
                        m_modo = 2; m_rest = TE;
                    end else begin
                        m_modo = 0; m_bebida = 4'd0;
                    end
                end
            end
            m_armado = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (comparar && rst_n) begin
            conferir("m_estado",   {1'b0, barramento.estado}, 4'(m_modo));
            conferir("m_led",      barramento.led_bebida, (m_modo == 1 || m_modo == 2) ? m_bebida : 4'd0);
            conferir("m_erro",     {3'b0, barramento.led_erro}, {3'b0, m_modo == 3});
            conferir("m_ocupado",  {3'b0, barramento.ocupado},  {3'b0, m_modo != 0});
            conferir("m_entregue", {3'b0, barramento.entregue}, {3'b0, (m_modo == 2) && (m_rest == 1)});
        end
    end

    initial begin
        rst_n = 1'b0;
        entrada(3'b000, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        tudo_zero("reset");
        #1 rst_n = 1'b1;
        comparar = 1'b1;
        @(negedge clk);

        // Valid espresso purchase: full PREPARO then ENTREGA.
        #1 entrada(3'b001, c_BT_CAFE_EXPRESSO, 1'b0);
        for (int i = 1; i <= TP; i++) begin
            @(negedge clk);
            conferir("prep_estado", {1'b0, barramento.estado}, 4'd1);
            conferir("prep_led", barramento.led_bebida, 4'b1000);
            if (i == 1) #1 barramento.bt = 4'b0000;
        end
        for (int j = 1; j <= TE; j++) begin
            @(negedge clk);
            conferir("entr_estado", {1'b0, barramento.estado}, 4'd2);
            conferir("entr_pulso", {3'b0, barramento.entregue}, {3'b0, j == TE});
        end
        @(negedge clk);
        tudo_zero("pos_entrega");

        // No note inserted -> ERRO.
        #1 entrada(3'b000, c_BT_CAPUCCINO, 1'b0);
        for (int i = 1; i <= TR; i++) begin
            @(negedge clk);
            conferir("erro_estado", {1'b0, barramento.estado}, 4'd3);
            conferir("erro_led", {3'b0, barramento.led_erro}, 4'd1);
            conferir("erro_bebida", barramento.led_bebida, 4'd0);
            conferir("erro_entregue", {3'b0, barramento.entregue}, 4'd0);
            if (i == 1) #1 barramento.bt = 4'b0000;
        end
        @(negedge clk);
        conferir("pos_erro", {1'b0, barramento.estado}, 4'd0);

        // Two buttons at once -> ERRO.
        #1 entrada(3'b010, 4'b0011, 1'b0);
        @(negedge clk);
        conferir("dois_bt", {1'b0, barramento.estado}, 4'd3);
        #1 barramento.bt = 4'b0000;
        repeat (TR) @(negedge clk);
        conferir("dois_bt_fim", {1'b0, barramento.estado}, 4'd0);

        // Value mismatch -> ERRO.
        #1 entrada(3'b010, c_BT_CAPUCCINO, 1'b1);
        @(negedge clk);
        conferir("d_valor", {1'b0, barramento.estado}, 4'd3);
        #1 entrada(3'b010, 4'b0000, 1'b0);
        repeat (TR) @(negedge clk);
        conferir("d_valor_fim", {1'b0, barramento.estado}, 4'd0);

        // Edge during ERRO is ignored.
        #1 entrada(3'b000, c_BT_CHA_CAMOMILA, 1'b0);
        @(negedge clk);
        #1 barramento.bt = 4'b0000;
        @(negedge clk);
        #1 entrada(3'b001, c_BT_CAFE_EXPRESSO, 1'b0);
        @(negedge clk);
        conferir("ign_erro", {1'b0, barramento.estado}, 4'd3);
        #1 barramento.bt = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            conferir("ign_erro_fim", {1'b0, barramento.estado}, 4'd0);
        end

        // Held button through the whole sequence; extra edge during ENTREGA.
        #1 entrada(3'b001, c_BT_CAFE_LEITE, 1'b0);
        for (int i = 1; i <= TP; i++) begin
            @(negedge clk);
            conferir("seg_prep", {1'b0, barramento.estado}, 4'd1);
            conferir("seg_led", barramento.led_bebida, 4'b0010);
        end
        for (int j = 1; j <= TE; j++) begin
            @(negedge clk);
            conferir("seg_entr", {1'b0, barramento.estado}, 4'd2);
            if (j == 2) #1 barramento.bt = 4'b0110;
            if (j == 3) #1 barramento.bt = 4'b0010;
        end
        repeat (3) begin
            @(negedge clk);
            conferir("seg_ocioso", {1'b0, barramento.estado}, 4'd0);
        end
        #1 barramento.bt = 4'b0000;
        @(negedge clk);
        #1 barramento.bt = c_BT_CAFE_LEITE;
        @(negedge clk);
        conferir("reaperto", {1'b0, barramento.estado}, 4'd1);
        #1 barramento.bt = 4'b0000;

        // Asynchronous reset at PREPARO cycle 5, button held across release.
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 tudo_zero("reset_async");
        entrada(3'b001, c_BT_CAPUCCINO, 1'b0);
        repeat (2) @(negedge clk);
        tudo_zero("reset_mantido");
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            conferir("bt_pos_reset", {1'b0, barramento.estado}, 4'd0);
        end
        #1 barramento.bt = 4'b0000;
        @(negedge clk);
        #1 barramento.bt = c_BT_CAPUCCINO;
        @(negedge clk);
        conferir("novo_pos_reset", {1'b0, barramento.estado}, 4'd1);
        #1 barramento.bt = 4'b0000;
        repeat (TP + TE + 2) @(negedge clk);

        // Randomized traffic with one asynchronous reset pulse.
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    barramento.bt = 4'b0000;
                    2, 3:    barramento.bt = 4'b0001 << $urandom_range(0, 3);
                    4:       barramento.bt = 4'($urandom_range(0, 15));
                    default: barramento.bt = barramento.bt;
                endcase
            end
            barramento.chaves_cedulas = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            barramento.d_valor        = ($urandom_range(0, 4) == 0);
            if (k == 400) begin
                #1 rst_n = 1'b0;
                #1 tudo_zero("reset_aleat");
                #1 rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule
`default_nettype wire
